br_resolve: RTL and testbench

Branch resolution controller sitting directly downstream of the ID-stage branch unit: it consumes that unit's per-cycle `realj` / `wait_seg` verdict and turns it into ID stalls and a PC redirect. When a branch operand is still being produced by a load in EX or EC, it holds the branch in ID for the required number of pipeline advances. It then samples the forwarded taken/not-taken decision and presents a held redirect (target PC) to the PC/IF unit through a valid/ready handshake.

---
 rtl/br_resolve.sv | 129 ++++++++++++
 tb/tb_br_resolve.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve.sv
// Branch resolution controller: holds a branch in ID until its load-dependent operands
// arrive, then issues a held PC redirect over a valid/ready handshake.
// Optional statistics counters are enabled by defining BR_RESOLVE_STAT_EN.
module br_resolve (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        adv,
  input  logic        id_br,
  input  logic        realj,
  input  logic [1:0]  wait_seg,
  input  logic [31:0] br_target,
  input  logic        br_ready,
  output logic        id_stall,
  output logic        br_valid,
  output logic [31:0] br_pc
`ifdef BR_RESOLVE_STAT_EN
  ,
  output logic [31:0] br_total,
  output logic [31:0] br_taken
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } st_e;

  st_e         st_q, st_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] br_pc_q, br_pc_d;
  logic [1:0]  seg_eff;
  logic        resolve;
  logic        take;

  // A wait of 3 stages cannot occur in this pipeline; saturate it to 2.
  assign seg_eff = (wait_seg == 2'd3) ? 2'd2 : wait_seg;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    br_pc_d = br_pc_q;
    resolve = 1'b0;
    take    = 1'b0;
    if (flush) begin
      st_d  = IDLE;
      cnt_d = 2'd0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (id_br) begin
            if (seg_eff == 2'd0) begin
              resolve = 1'b1;
              take    = realj;
            end else begin
              st_d  = WAIT;
              cnt_d = seg_eff;
            end
          end
        end
        WAIT: begin
          if (cnt_q != 2'd0) begin
            if (adv) cnt_d = cnt_q - 2'd1;
          end else begin
            resolve = 1'b1;
            take    = realj;
          end
        end
        SEND: begin
          if (br_ready) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
      if (resolve) begin
        st_d = take ? SEND : IDLE;
        if (take) br_pc_d = br_target;
      end
    end
  end

  // Flush and reset must silence the outputs in the same cycle, so these stay combinational.
  always_comb begin
    id_stall = 1'b0;
    if (resetn && !flush) begin
      unique case (st_q)
        IDLE:    id_stall = id_br && (seg_eff != 2'd0);
        WAIT:    id_stall = (cnt_q != 2'd0);
        SEND:    id_stall = id_br;
        default: id_stall = 1'b0;
      endcase
    end
  end

  assign br_valid = (st_q == SEND) && !flush;
  assign br_pc    = br_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q    <= IDLE;
      cnt_q   <= 2'd0;
      br_pc_q <= 32'd0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      br_pc_q <= br_pc_d;
    end
  end

`ifdef BR_RESOLVE_STAT_EN
  logic [31:0] total_q, taken_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      total_q <= 32'd0;
      taken_q <= 32'd0;
    end else begin
      total_q <= total_q + {31'd0, resolve};
      taken_q <= taken_q + {31'd0, take};
    end
  end

  assign br_total = total_q;
  assign br_taken = taken_q;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_br_resolve;

  logic        clk;
  logic        resetn;
  logic        flush, adv, id_br, realj, br_ready;
  logic [1:0]  wait_seg;
  logic [31:0] br_target;
  logic        id_stall, br_valid;
  logic [31:0] br_pc;
`ifdef BR_RESOLVE_STAT_EN
  logic [31:0] br_total, br_taken;
`endif

  br_resolve dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .adv       (adv),
    .id_br     (id_br),
    .realj     (realj),
    .wait_seg  (wait_seg),
    .br_target (br_target),
    .br_ready  (br_ready),
    .id_stall  (id_stall),
    .br_valid  (br_valid),
    .br_pc     (br_pc)
`ifdef BR_RESOLVE_STAT_EN
    ,
    .br_total  (br_total),
    .br_taken  (br_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a held branch needs m_need more advances (-1 = none held);
  // m_send marks an outstanding redirect to m_pc.
  int          m_need;
  bit          m_send;
  logic [31:0] m_pc;
  int unsigned m_total, m_taken;

  task automatic model_reset();
    m_need = -1; m_send = 0; m_pc = 32'd0; m_total = 0; m_taken = 0;
  endtask

  task automatic model_resolve();
    m_total++;
    if (realj) begin
      m_send = 1; m_pc = br_target; m_taken++;
    end
    m_need = -1;
  endtask

  task automatic model_step();
    int n;
    if (!resetn) begin
      model_reset();
    end else if (flush) begin
      m_need = -1; m_send = 0;
    end else if (m_send) begin
      if (br_ready) m_send = 0;
    end else if (m_need > 0) begin
      if (adv) m_need--;
    end else if (m_need == 0) begin
      model_resolve();
    end else if (id_br) begin
      n = (wait_seg > 2'd2) ? 2 : int'(wait_seg);
      if (n == 0) model_resolve();
      else m_need = n;
    end
  endtask

  function automatic logic exp_stall();
    if (!resetn || flush) return 1'b0;
    if (m_send) return id_br;
    if (m_need > 0) return 1'b1;
    if (m_need == 0) return 1'b0;
    return id_br && (wait_seg != 2'd0);
  endfunction

  task automatic drive(input logic fl, input logic ad, input logic ib, input logic rj,
                       input logic [1:0] ws, input logic [31:0] tg, input logic rd);
    flush = fl; adv = ad; id_br = ib; realj = rj; wait_seg = ws; br_target = tg; br_ready = rd;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fl, ad, ib, rj;
    logic [1:0]  ws;
    logic [31:0] tg;
    logic        rd;
    logic        es, ev;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic ad, input logic ib, input logic rj,
                     input logic [1:0] ws, input logic [31:0] tg, input logic rd,
                     input logic es, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.fl = fl; v.ad = ad; v.ib = ib; v.rj = rj; v.ws = ws; v.tg = tg; v.rd = rd;
    v.es = es; v.ev = ev; v.ep = ep;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned snap_total, snap_taken;

    // Reset: a branch request must not stall while reset is held.
    resetn = 1'b0;
    drive(0, 1, 1, 1, 2'd2, 32'h1234_5678, 0);
    model_reset();
    settle();
    check("stall_in_reset", {31'd0, id_stall}, 32'd0);
    check("valid_in_reset", {31'd0, br_valid}, 32'd0);
    check("pc_in_reset", br_pc, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(0, 0, 0, 0, 2'd0, 32'd0, 0);
    settle();
    check("idle_after_reset", {30'd0, id_stall, br_valid}, 32'd0);
    advance();

    // Zero-wait taken, load in EX (not taken), stalled advance, saturated wait.
    //   fl ad ib rj ws     target         rd  stall valid pc
    add(0, 0, 1, 1, 2'd0, 32'h8000_1000, 1, 0, 0, 32'h0000_0000);
    add(0, 0, 0, 0, 2'd0, 32'h0,         1, 0, 1, 32'h8000_1000);
    add(0, 0, 0, 0, 2'd0, 32'h0,         1, 0, 0, 32'h8000_1000);
    add(0, 1, 1, 0, 2'd2, 32'h1234_5678, 1, 1, 0, 32'h8000_1000);
    add(0, 1, 1, 0, 2'd2, 32'h1234_5678, 1, 1, 0, 32'h8000_1000);
    add(0, 1, 1, 0, 2'd2, 32'h1234_5678, 1, 1, 0, 32'h8000_1000);
    add(0, 1, 1, 0, 2'd2, 32'h1234_5678, 1, 0, 0, 32'h8000_1000);
    add(0, 1, 0, 0, 2'd0, 32'h0,         1, 0, 0, 32'h8000_1000);
    add(0, 0, 1, 1, 2'd1, 32'hA000_0040, 0, 1, 0, 32'h8000_1000);
    add(0, 0, 1, 1, 2'd1, 32'hA000_0040, 0, 1, 0, 32'h8000_1000);
    add(0, 0, 1, 1, 2'd1, 32'hA000_0040, 0, 1, 0, 32'h8000_1000);
    add(0, 1, 1, 1, 2'd1, 32'hA000_0040, 0, 1, 0, 32'h8000_1000);
    add(0, 0, 1, 1, 2'd1, 32'hA000_0040, 0, 0, 0, 32'h8000_1000);
    add(0, 0, 0, 0, 2'd0, 32'h0,         0, 0, 1, 32'hA000_0040);
    add(0, 0, 0, 0, 2'd0, 32'h0,         1, 0, 1, 32'hA000_0040);
    add(0, 0, 0, 0, 2'd0, 32'h0,         1, 0, 0, 32'hA000_0040);
    add(0, 1, 1, 0, 2'd3, 32'h5555_0000, 1, 1, 0, 32'hA000_0040);
    add(0, 1, 1, 0, 2'd3, 32'h5555_0000, 1, 1, 0, 32'hA000_0040);
    add(0, 1, 1, 0, 2'd3, 32'h5555_0000, 1, 1, 0, 32'hA000_0040);
    add(0, 1, 1, 0, 2'd3, 32'h5555_0000, 1, 0, 0, 32'hA000_0040);
    add(0, 0, 0, 0, 2'd0, 32'h0,         1, 0, 0, 32'hA000_0040);

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].ad, vecs[i].ib, vecs[i].rj, vecs[i].ws, vecs[i].tg, vecs[i].rd);
      settle();
      check($sformatf("vec%0d_stall", i), {31'd0, id_stall}, {31'd0, vecs[i].es});
      check($sformatf("vec%0d_valid", i), {31'd0, br_valid}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d_pc", i), br_pc, vecs[i].ep);
      advance();
    end

    // Handshake backpressure with a second branch waiting in ID.
    drive(0, 0, 1, 1, 2'd0, 32'hBFC0_0100, 0);
    settle();
    check("bp_entry_stall", {31'd0, id_stall}, 32'd0);
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 1, 2'd0, 32'h1111_0000, (c == 3) ? 1'b1 : 1'b0);
      settle();
      check($sformatf("bp%0d_valid", c), {31'd0, br_valid}, 32'd1);
      check($sformatf("bp%0d_pc", c), br_pc, 32'hBFC0_0100);
      check($sformatf("bp%0d_stall", c), {31'd0, id_stall}, 32'd1);
      advance();
    end
    settle();
    check("bp_next_eval_stall", {31'd0, id_stall}, 32'd0);
    check("bp_next_eval_valid", {31'd0, br_valid}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 2'd0, 32'h0, 1);
    settle();
    check("bp_second_valid", {31'd0, br_valid}, 32'd1);
    check("bp_second_pc", br_pc, 32'h1111_0000);
    advance();

    // Flush while one advance is still outstanding.
    snap_total = m_total;
    snap_taken = m_taken;
    drive(0, 1, 1, 1, 2'd1, 32'hDEAD_0000, 0);
    settle();
    check("fl_entry_stall", {31'd0, id_stall}, 32'd1);
    advance();
    drive(1, 0, 1, 1, 2'd1, 32'hDEAD_0000, 1);
    settle();
    check("fl_cycle_stall", {31'd0, id_stall}, 32'd0);
    check("fl_cycle_valid", {31'd0, br_valid}, 32'd0);
    advance();
    drive(0, 1, 0, 1, 2'd0, 32'h0, 1);
    settle();
    check("fl_after_stall", {31'd0, id_stall}, 32'd0);
    check("fl_after_valid", {31'd0, br_valid}, 32'd0);
    advance();
    settle();
    check("fl_no_redirect", {31'd0, br_valid}, 32'd0);
    check("fl_pc_kept", br_pc, 32'h1111_0000);
`ifdef BR_RESOLVE_STAT_EN
    check("fl_total_unchanged", br_total, snap_total);
    check("fl_taken_unchanged", br_taken, snap_taken);
`endif
    advance();

    // Reset asserted mid-SEND.
    drive(0, 0, 1, 1, 2'd0, 32'hBFC0_0100, 0);
    settle();
    advance();
    drive(0, 0, 1, 0, 2'd0, 32'h0, 0);
    #1;
    check("rst_pre_valid", {31'd0, br_valid}, 32'd1);
    check("rst_pre_stall", {31'd0, id_stall}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_now_valid", {31'd0, br_valid}, 32'd0);
    check("rst_now_stall", {31'd0, id_stall}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    settle();
    check("rst_after_pc", br_pc, 32'd0);
    check("rst_after_valid", {31'd0, br_valid}, 32'd0);
    advance();
    drive(0, 0, 1, 0, 2'd0, 32'h0, 0);
    settle();
    check("rst_idle_stall", {31'd0, id_stall}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 2'd0, 32'h0, 0);
    settle();
    check("rst_idle_valid", {31'd0, br_valid}, 32'd0);
    advance();

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 20) == 0, $urandom % 2 == 0, ($urandom % 3) != 0, $urandom % 2 == 0,
            2'($urandom % 4), $urandom, ($urandom % 3) != 0);
      settle();
      check("rnd_stall", {31'd0, id_stall}, {31'd0, exp_stall()});
      check("rnd_valid", {31'd0, br_valid}, {31'd0, m_send && !flush});
      check("rnd_pc", br_pc, m_pc);
`ifdef BR_RESOLVE_STAT_EN
      check("rnd_total", br_total, m_total);
      check("rnd_taken", br_taken, m_taken);
`endif
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
